inst_fetch_ctrl: RTL and testbench

Fetch sequencer between the PC register and instruction memory in the 54-instruction single-cycle CPU. It issues a request to a variable-latency instruction memory at the current PC and holds the returned word for the datapath. It drives the PC register's enable so the PC advances exactly once per retired instruction, and stalls while a multi-cycle unit (DIV/DIVU/MULT) is busy. It flags misaligned fetches and memory timeouts as a sticky error.

---
 rtl/inst_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer between the PC register and imem.
// Requests at pc, holds the word for decode, paces PC updates.
//   in : clk, rst, pc, imem_ack, imem_rdata, exec_stall
//   out: pc_ena, imem_req, imem_addr, inst, inst_valid,
//        fetch_err, err_addr, inst_count
module inst_fetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              exec_stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  inst_count
);

  localparam int TO_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TO_W-1:0] TO_MAX = '1;

  typedef enum logic [1:0] {
    S_REQ,
    S_EXEC,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                misaligned;
  logic                expire;

  assign imem_addr  = pc;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign fetch_err  = err_q;
  assign err_addr   = err_addr_q;
  assign inst_count = cnt_q;

  assign misaligned = |pc[1:0];
  // Watchdog fires on the last allowed cycle; an ack
  // in that same cycle still takes priority below.
  assign expire = (TIMEOUT != 0) && (to_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    pc_ena     = 1'b0;
    imem_req   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (misaligned) begin
          err_d      = 1'b1;
          err_addr_d = pc;
          state_d    = S_ERR;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            inst_d  = imem_rdata;
            valid_d = 1'b1;
            to_d    = '0;
            state_d = S_EXEC;
          end else begin
            if (to_q != TO_MAX)
              to_d = to_q + TO_W'(1);
            if (expire) begin
              err_d      = 1'b1;
              err_addr_d = pc;
              state_d    = S_ERR;
            end
          end
        end
      end
      S_EXEC: begin
        pc_ena = !exec_stall;
        if (!exec_stall) begin
          cnt_d   = cnt_q + CNT_W'(1);
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
    // Keep the PC and memory quiet while reset is held.
    if (rst) begin
      pc_ena   = 1'b0;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: bench for inst_fetch_ctrl.
// Models the PC register and a variable-latency imem.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        exec_stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] err_addr;
  logic [31:0] inst_count;

  logic [31:0] pc_rst_val = 32'h0040_0000;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int          lat;
    int          stall;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] count;
  } sb_t;

  sb_t sbq[$];
  int  n_ret = 0;

  inst_fetch_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16),
    .CNT_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_ena    (pc_ena),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .exec_stall(exec_stall),
    .inst      (inst),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err),
    .err_addr  (err_addr),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst)
      pc <= pc_rst_val;
    else if (pc_ena)
      pc <= pc + 32'd4;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_pc_ena", pc_ena, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_count", inst_count, 0);
  endtask

  task automatic do_reset(input logic [31:0] rv);
    @(posedge clk);
    #1;
    pc_rst_val = rv;
    imem_ack   = 1'b0;
    exec_stall = 1'b0;
    rst        = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    n_ret = 0;
  endtask

  task automatic run_inst(input vec_t v);
    sb_t e;
    for (int c = 0; c <= v.lat; c++) begin
      @(negedge clk);
      imem_ack   = (c == v.lat);
      imem_rdata = (c == v.lat) ? v.rdata
                                : 32'hdead_beef;
      #1;
      chk("req", imem_req, 1);
      chk("req_addr", imem_addr, v.exp_addr);
      chk("req_pc_ena", pc_ena, 0);
      chk("req_valid", inst_valid, 0);
      chk("req_err", fetch_err, 0);
      if (c == v.lat) begin
        n_ret++;
        sbq.push_back('{v.exp_addr, v.rdata,
                        32'(n_ret)});
      end
    end
    for (int s = 0; s <= v.stall; s++) begin
      @(negedge clk);
      exec_stall = (s < v.stall);
      // stray acks during EXEC must be ignored
      imem_ack   = (s < v.stall);
      imem_rdata = 32'hbad0_0bad;
      #1;
      chk("exec_req", imem_req, 0);
      chk("exec_valid", inst_valid, 1);
      chk("exec_pc_ena", pc_ena, s == v.stall);
      chk("exec_addr", imem_addr, v.exp_addr);
      chk("exec_inst", inst, v.rdata);
      if (s < v.stall) begin
        chk("stall_count", inst_count, n_ret - 1);
      end else begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_addr", imem_addr, e.addr);
          @(posedge clk);
          #1;
          chk("ret_count", inst_count, e.count);
          chk("ret_valid", inst_valid, 0);
          chk("ret_pc", pc, e.addr + 32'd4);
        end
      end
    end
    exec_stall = 1'b0;
    imem_ack   = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int   c0;
    tbl[0] = '{0, 0, 32'h3c01_0040, 32'h0040_0000};
    tbl[1] = '{0, 0, 32'h3421_0000, 32'h0040_0004};
    tbl[2] = '{0, 0, 32'h0020_2020, 32'h0040_0008};
    tbl[3] = '{3, 0, 32'h2408_0005, 32'h0040_000c};
    tbl[4] = '{0, 5, 32'h0109_001a, 32'h0040_0010};
    tbl[5] = '{15, 0, 32'h8d09_0004, 32'h0040_0014};
    tbl[6] = '{15, 1, 32'had09_0008, 32'h0040_0018};
    tbl[7] = '{1, 2, 32'h1000_ffff, 32'h0040_001c};

    imem_ack   = 1'b0;
    imem_rdata = '0;
    exec_stall = 1'b0;

    do_reset(32'h0040_0000);

    // back-to-back fetches with zero-latency memory
    c0 = cyc;
    for (int i = 0; i < 3; i++) run_inst(tbl[i]);
    chk("tp_cycles", cyc - c0, 6);
    chk("tp_count", inst_count, 3);

    // latency, stalls, ack on the watchdog's last cycle
    for (int i = 3; i < 8; i++) run_inst(tbl[i]);

    // async reset in the middle of a long request
    @(negedge clk);
    #1;
    chk("mid_req0", imem_req, 1);
    @(negedge clk);
    #1;
    chk("mid_req1", imem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    chk("mid_rst_addr", imem_addr, 32'h0040_0000);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hbad0_0bad;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("late_ack_inst", inst, 0);
    chk("late_ack_valid", inst_valid, 0);
    chk("late_ack_count", inst_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    n_ret = 0;
    run_inst('{2, 0, 32'h2402_0001, 32'h0040_0000});

    // watchdog: memory never acks
    do_reset(32'h0040_0010);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1;
      chk("to_req", imem_req, 1);
      chk("to_err_early", fetch_err, 0);
    end
    @(negedge clk);
    #1;
    chk("to_err", fetch_err, 1);
    chk("to_err_addr", err_addr, 32'h0040_0010);
    chk("to_req_off", imem_req, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      #1;
      chk("err_hold", fetch_err, 1);
      chk("err_req", imem_req, 0);
      chk("err_pc_ena", pc_ena, 0);
      chk("err_valid", inst_valid, 0);
      chk("err_inst", inst, 0);
      chk("err_pc", pc, 32'h0040_0010);
    end
    imem_ack = 1'b0;

    // misaligned PC
    do_reset(32'h0040_0006);
    @(negedge clk);
    #1;
    chk("mis_req", imem_req, 0);
    chk("mis_pc_ena", pc_ena, 0);
    @(negedge clk);
    #1;
    chk("mis_err", fetch_err, 1);
    chk("mis_err_addr", err_addr, 32'h0040_0006);
    chk("mis_req2", imem_req, 0);
    chk("mis_pc_ena2", pc_ena, 0);

    // recovery after an error
    do_reset(32'h0040_0000);
    run_inst('{1, 1, 32'h0800_0000, 32'h0040_0000});

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
